// File: rtl/maclaurin_job_scheduler.sv
// Request front-end for the Maclaurin series calculator: queues (func, x, tag) jobs,
// runs them one at a time through the calculator and returns tagged results.
`timescale 1ns/1ps
module maclaurin_job_scheduler #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_func,
  input  logic [15:0]      req_x,
  input  logic [TAG_W-1:0] req_tag,
  output logic             calc_start,
  output logic [1:0]       calc_func,
  output logic [15:0]      calc_xBus,
  input  logic [17:0]      calc_rBus,
  input  logic             calc_done,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [17:0]      res_data,
  output logic [1:0]       res_func,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_timeout,
  output logic             busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int EW = 2 + 16 + TAG_W;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] ARM   = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] HOLD  = 3'd4;

  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [2:0]       state;
  logic [TW-1:0]    timer;
  logic [TAG_W-1:0] tag_reg;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign full       = (count == (AW+1)'(DEPTH));
  assign empty      = (count == '0);
  assign push       = req_valid && !full;
  assign pop        = (state == IDLE) && !empty;
  assign req_ready  = !full;
  assign calc_start = (state == ISSUE);
  assign busy       = (state != IDLE) || !empty;

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {req_func, req_x, req_tag};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // ARM is a deliberate one-cycle blind spot so a done level left over from
  // the previous job cannot complete the new one before it has started.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      tag_reg     <= '0;
      calc_func   <= '0;
      calc_xBus   <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_func    <= '0;
      res_tag     <= '0;
      res_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            {calc_func, calc_xBus, tag_reg} <= mem[rd_ptr];
            state <= ISSUE;
          end
        end
        ISSUE: state <= ARM;
        ARM: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (calc_done) begin
            res_data    <= calc_rBus;
            res_timeout <= 1'b0;
            res_valid   <= 1'b1;
            res_func    <= calc_func;
            res_tag     <= tag_reg;
            state       <= HOLD;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            res_data    <= '0;
            res_timeout <= 1'b1;
            res_valid   <= 1'b1;
            res_func    <= calc_func;
            res_tag     <= tag_reg;
            state       <= HOLD;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
